// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : owns the PC, drives instruction memory, captures IF/ID and
//                   halts after a run of HALT_NOOPS consecutive NOOP fetches.
// Revision        : 1.0
// ============================================================================
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned HALT_NOOPS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        running,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [4:0] c_halt_noops = 5'(HALT_NOOPS);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_if_valid;
  logic        r_running;
  logic        r_halted;
  logic [31:0] r_fetch_count;
  logic [3:0]  r_noop_run;

  logic        w_is_noop;
  logic [4:0]  w_noop_inc;
  logic [3:0]  w_noop_next;
  logic        w_halt_now;

  assign w_is_noop   = (imem_instr == 32'h0);
  assign w_noop_inc  = {1'b0, r_noop_run} + 5'd1;
  assign w_noop_next = (r_noop_run == 4'hF) ? 4'hF : w_noop_inc[3:0];
  // The halting NOOP is itself captured; only the state changes with it.
  assign w_halt_now  = w_is_noop && (w_noop_inc == c_halt_noops);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_if_instr    <= 32'h0;
      r_if_pc       <= 32'h0;
      r_if_valid    <= 1'b0;
      r_running     <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= 32'h0;
      r_noop_run    <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_noop_run    <= 4'h0;
            r_fetch_count <= 32'h0;
            r_if_valid    <= 1'b0;
            r_running     <= 1'b1;
            r_halted      <= 1'b0;
          end
        end

        S_RUN: begin
          if (redirect) begin
            r_pc       <= redirect_pc;
            r_if_valid <= 1'b0;
            r_if_instr <= 32'h0;
            r_noop_run <= 4'h0;
          end else if (!stall) begin
            r_if_instr    <= imem_instr;
            r_if_pc       <= r_pc;
            r_if_valid    <= 1'b1;
            r_pc          <= r_pc + 32'd1;
            r_fetch_count <= r_fetch_count + 32'd1;
            r_noop_run    <= w_is_noop ? w_noop_next : 4'h0;
            if (w_halt_now) begin
              r_state   <= S_HALT;
              r_running <= 1'b0;
              r_halted  <= 1'b1;
            end
          end
        end

        S_HALT: begin
          r_if_valid <= 1'b0;
          if (start) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_noop_run    <= 4'h0;
            r_fetch_count <= 32'h0;
            r_running     <= 1'b1;
            r_halted      <= 1'b0;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_halted  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_pc     = r_pc;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_valid    = r_if_valid;
  assign running     = r_running;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : directed scenarios plus a randomized run against a
//                      behavioural fetch model.
// Revision           : 1.0
// ============================================================================
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] mem [0:63];

  logic [31:0] imem_instr, imem_pc, if_instr, if_pc, fetch_count;
  logic        if_valid, running, halted;

  logic [31:0] imem_instr2, imem_pc2, if_instr2, if_pc2, fetch_count2;
  logic        if_valid2, running2, halted2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_instr  = mem[imem_pc[5:0]];
  assign imem_instr2 = (imem_pc2 == 32'h0) ? 32'h0 : {imem_pc2[30:0], 1'b1};

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_instr(imem_instr),
    .imem_pc(imem_pc), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .running(running), .halted(halted), .fetch_count(fetch_count)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFF), .HALT_NOOPS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_instr(imem_instr2),
    .imem_pc(imem_pc2), .if_instr(if_instr2), .if_pc(if_pc2), .if_valid(if_valid2),
    .running(running2), .halted(halted2), .fetch_count(fetch_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    #12;
    n_checks++;
    if (imem_pc !== 32'h0 || if_instr !== 32'h0 || if_pc !== 32'h0 || if_valid !== 1'b0 ||
        running !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%h instr=%h ifpc=%h v=%b run=%b halt=%b cnt=%0d, expected all zero",
               imem_pc, if_instr, if_pc, if_valid, running, halted, fetch_count);
    end
    n_checks++;
    if (imem_pc2 !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL reset_pc_param: got %h expected ffffffff", imem_pc2);
    end
    rst_n = 1'b1;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'd9;
    tick(); tick();
    stall = 1'b0; redirect = 1'b0;
    n_checks++;
    if (running !== 1'b0 || imem_pc !== 32'h0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_redirect: got run=%b pc=%h v=%b expected 0/0/0", running, imem_pc, if_valid);
    end
  endtask

  task automatic test_program_end();
    for (int i = 0; i < 64; i++) mem[i] = (i < 6) ? (32'hA000_0000 + 32'(i)) : 32'h0;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (running !== 1'b1 || imem_pc !== 32'h0 || if_valid !== 1'b0 || fetch_count !== 32'h0) begin
      n_fail++;
      $display("FAIL start_cycle: got run=%b pc=%h v=%b cnt=%0d expected 1/0/0/0", running, imem_pc, if_valid, fetch_count);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (if_pc !== 32'(k) || if_valid !== 1'b1 || if_instr !== mem[k] || halted !== (k == 7)) begin
        n_fail++;
        $display("FAIL capture_%0d: got ifpc=%h v=%b instr=%h halt=%b expected ifpc=%h v=1 instr=%h halt=%b",
                 k, if_pc, if_valid, if_instr, halted, 32'(k), mem[k], (k == 7));
      end
    end
    tick();
    n_checks++;
    if (imem_pc !== 32'd8 || fetch_count !== 32'd8 || if_valid !== 1'b0 || halted !== 1'b1 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_state: got pc=%h cnt=%0d v=%b halt=%b run=%b expected 8/8/0/1/0",
               imem_pc, fetch_count, if_valid, halted, running);
    end
    redirect = 1'b1; redirect_pc = 32'd3;
    tick(); tick();
    redirect = 1'b0;
    n_checks++;
    if (imem_pc !== 32'd8 || halted !== 1'b1 || fetch_count !== 32'd8) begin
      n_fail++;
      $display("FAIL halt_frozen: got pc=%h halt=%b cnt=%0d expected 8/1/8", imem_pc, halted, fetch_count);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 | 32'(i);
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (imem_pc !== 32'h0 || halted !== 1'b0 || running !== 1'b1 || fetch_count !== 32'h0) begin
      n_fail++;
      $display("FAIL restart_from_halt: got pc=%h halt=%b run=%b cnt=%0d expected 0/0/1/0",
               imem_pc, halted, running, fetch_count);
    end
    repeat (4) tick();
    stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_checks++;
      if (imem_pc !== 32'd4 || if_pc !== 32'd3 || if_instr !== mem[3] || fetch_count !== 32'd4 || if_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got pc=%h ifpc=%h instr=%h cnt=%0d v=%b expected 4/3/%h/4/1",
                 j, imem_pc, if_pc, if_instr, fetch_count, if_valid, mem[3]);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (if_pc !== 32'd4 || fetch_count !== 32'd5 || imem_pc !== 32'd5) begin
      n_fail++;
      $display("FAIL stall_release: got ifpc=%h cnt=%0d pc=%h expected 4/5/5", if_pc, fetch_count, imem_pc);
    end
  endtask

  task automatic test_redirect();
    int guard = 0;
    while (imem_pc !== 32'd13 && guard < 64) begin
      tick();
      guard++;
    end
    n_checks++;
    if (imem_pc !== 32'd13) begin
      n_fail++;
      $display("FAIL reach_pc13: got %h expected 0000000d", imem_pc);
    end
    redirect = 1'b1; redirect_pc = 32'd10; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    n_checks++;
    if (imem_pc !== 32'd10 || if_valid !== 1'b0 || if_instr !== 32'h0 || fetch_count !== 32'd13) begin
      n_fail++;
      $display("FAIL redirect_flush: got pc=%h v=%b instr=%h cnt=%0d expected 10/0/0/13",
               imem_pc, if_valid, if_instr, fetch_count);
    end
    tick();
    n_checks++;
    if (if_pc !== 32'd10 || if_valid !== 1'b1 || fetch_count !== 32'd14 || if_instr !== mem[10]) begin
      n_fail++;
      $display("FAIL redirect_target: got ifpc=%h v=%b cnt=%0d expected 10/1/14", if_pc, if_valid, fetch_count);
    end
  endtask

  task automatic test_noop_pattern();
    mem[20] = 32'h0; mem[21] = 32'h1234_5678; mem[22] = 32'h0;
    mem[30] = 32'h0; mem[40] = 32'h0; mem[41] = 32'h0;
    redirect = 1'b1; redirect_pc = 32'd20; tick(); redirect = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      n_checks++;
      if (halted !== 1'b0 || if_pc !== 32'(20 + j)) begin
        n_fail++;
        $display("FAIL noop_pattern_%0d: got halt=%b ifpc=%h expected 0/%h", j, halted, if_pc, 32'(20 + j));
      end
    end
    redirect = 1'b1; redirect_pc = 32'd30; tick(); redirect = 1'b0;
    tick();
    redirect = 1'b1; tick(); redirect = 1'b0;
    tick(); tick();
    n_checks++;
    if (halted !== 1'b0 || if_pc !== 32'd31 || fetch_count !== 32'd22) begin
      n_fail++;
      $display("FAIL redirect_resets_noops: got halt=%b ifpc=%h cnt=%0d expected 0/31/22", halted, if_pc, fetch_count);
    end
    redirect = 1'b1; redirect_pc = 32'd40; tick(); redirect = 1'b0;
    tick();
    redirect = 1'b1; tick(); redirect = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || imem_pc !== 32'd40 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_beats_halt: got halt=%b pc=%h v=%b expected 0/40/0", halted, imem_pc, if_valid);
    end
    tick(); tick();
    n_checks++;
    if (halted !== 1'b1 || if_pc !== 32'd41 || if_valid !== 1'b1 || imem_pc !== 32'd42 || fetch_count !== 32'd25) begin
      n_fail++;
      $display("FAIL two_noop_halt: got halt=%b ifpc=%h v=%b pc=%h cnt=%0d expected 1/41/1/42/25",
               halted, if_pc, if_valid, imem_pc, fetch_count);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_pc !== 32'h0 || if_valid !== 1'b0 || fetch_count !== 32'h0 || running !== 1'b0 ||
        if_pc !== 32'h0 || if_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got pc=%h v=%b cnt=%0d run=%b ifpc=%h instr=%h expected all zero",
               imem_pc, if_valid, fetch_count, running, if_pc, if_instr);
    end
    #2;
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (imem_pc !== 32'h0 || if_valid !== 1'b0 || fetch_count !== 32'h0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL no_fetch_after_reset: got pc=%h v=%b cnt=%0d run=%b expected 0/0/0/0",
               imem_pc, if_valid, fetch_count, running);
    end
  endtask

  task automatic test_wrap_restart();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (running2 !== 1'b1 || imem_pc2 !== 32'hFFFF_FFFF || fetch_count2 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_start: got run=%b pc=%h cnt=%0d expected 1/ffffffff/0", running2, imem_pc2, fetch_count2);
    end
    tick();
    n_checks++;
    if (imem_pc2 !== 32'h0 || if_pc2 !== 32'hFFFF_FFFF || if_valid2 !== 1'b1 || fetch_count2 !== 32'd1 ||
        if_instr2 !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL pc_wrap: got pc=%h ifpc=%h v=%b cnt=%0d instr=%h expected 0/ffffffff/1/1/ffffffff",
               imem_pc2, if_pc2, if_valid2, fetch_count2, if_instr2);
    end
    tick();
    n_checks++;
    if (halted2 !== 1'b1 || if_pc2 !== 32'h0 || if_instr2 !== 32'h0 || imem_pc2 !== 32'd1 || fetch_count2 !== 32'd2) begin
      n_fail++;
      $display("FAIL single_noop_halt: got halt=%b ifpc=%h instr=%h pc=%h cnt=%0d expected 1/0/0/1/2",
               halted2, if_pc2, if_instr2, imem_pc2, fetch_count2);
    end
    tick();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (running2 !== 1'b1 || halted2 !== 1'b0 || imem_pc2 !== 32'hFFFF_FFFF || fetch_count2 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_restart: got run=%b halt=%b pc=%h cnt=%0d expected 1/0/ffffffff/0",
               running2, halted2, imem_pc2, fetch_count2);
    end
    tick();
    n_checks++;
    if (if_pc2 !== 32'hFFFF_FFFF || fetch_count2 !== 32'd1 || if_valid2 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_refetch: got ifpc=%h cnt=%0d v=%b expected ffffffff/1/1", if_pc2, fetch_count2, if_valid2);
    end
  endtask

  // Model: 0 = idle, 1 = fetching, 2 = program ended.
  task automatic test_random();
    int          mode;
    int          noops;
    logic [31:0] pc, ifi, ifp, cnt, ins;
    logic        ifv;
    start = 1'b0; stall = 1'b0; redirect = 1'b0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 9) < 4) ? 32'h0 : ($urandom | 32'h1);
    mode = 0; noops = 0; pc = 32'h0; ifi = 32'h0; ifp = 32'h0; cnt = 32'h0; ifv = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      start       = ($urandom_range(0, 9) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      redirect    = ($urandom_range(0, 6) == 0);
      redirect_pc = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1)))
                                                 : 32'($urandom_range(0, 63));
      ins = mem[pc[5:0]];
      if (mode == 0) begin
        if (start) begin mode = 1; pc = 32'h0; noops = 0; cnt = 32'h0; ifv = 1'b0; end
      end else if (mode == 1) begin
        if (redirect) begin
          pc = redirect_pc; ifv = 1'b0; ifi = 32'h0; noops = 0;
        end else if (!stall) begin
          ifi = ins; ifp = pc; ifv = 1'b1; pc = pc + 1; cnt = cnt + 1;
          noops = (ins == 32'h0) ? ((noops < 15) ? noops + 1 : 15) : 0;
          if (ins == 32'h0 && noops == 2) mode = 2;
        end
      end else begin
        ifv = 1'b0;
        if (start) begin mode = 1; pc = 32'h0; noops = 0; cnt = 32'h0; end
      end
      tick();
      n_checks++;
      if (imem_pc !== pc || if_instr !== ifi || if_pc !== ifp || if_valid !== ifv ||
          running !== (mode == 1) || halted !== (mode == 2) || fetch_count !== cnt) begin
        n_fail++;
        $display("FAIL random_%0d: got pc=%h instr=%h ifpc=%h v=%b run=%b halt=%b cnt=%0d expected pc=%h instr=%h ifpc=%h v=%b run=%b halt=%b cnt=%0d",
                 c, imem_pc, if_instr, if_pc, if_valid, running, halted, fetch_count,
                 pc, ifi, ifp, ifv, (mode == 1), (mode == 2), cnt);
      end
    end
    start = 1'b0; stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_program_end();
    test_stall();
    test_redirect();
    test_noop_pattern();
    test_async_reset();
    test_wrap_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
